// File: rtl/mean_block_streamer_pkg.sv
// mean_streamer_pkg: shared state encoding, default sizes and pointer-width helper for mean_block_streamer
package mean_streamer_pkg;
  typedef enum logic [1:0] {FILL, START, STREAM, WAIT_MEAN} state_t;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_TOTAL_SAMPLES = 64;
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/mean_block_streamer_if.sv
// mean_block_streamer_if: upstream valid/ready sample bus plus mean-unit signals (in_data/in_valid/in_ready, data_out/start_out, mean_in/mean_ready_in, mean_out/block_done/busy, timeout_err with MEAN_STREAMER_TIMEOUT_EN); slave = streamer, master = environment
interface mean_block_streamer_if import mean_streamer_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
  logic [DATA_WIDTH-1:0] in_data, data_out;
  logic in_valid, in_ready, start_out, mean_ready_in, block_done, busy;
  logic [2*DATA_WIDTH-1:0] mean_in, mean_out;
`ifdef MEAN_STREAMER_TIMEOUT_EN
  logic timeout_err;
`endif
  modport slave (
    input in_data, in_valid, mean_in, mean_ready_in,
    output in_ready, data_out, start_out, mean_out, block_done, busy
`ifdef MEAN_STREAMER_TIMEOUT_EN
    , output timeout_err
`endif
  );
  modport master (
    output in_data, in_valid, mean_in, mean_ready_in,
    input in_ready, data_out, start_out, mean_out, block_done, busy
`ifdef MEAN_STREAMER_TIMEOUT_EN
    , input timeout_err
`endif
  );
endinterface

// File: rtl/mean_block_streamer_sample_block_buffer.sv
// sample_block_buffer: DEPTH x DATA_WIDTH array, one write port and a registered read port that outputs 0 when re is low (ports clk, rst, we, wr_addr, wr_data, re, rd_addr, rd_data)
module sample_block_buffer import mean_streamer_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH = DEF_TOTAL_SAMPLES
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          we,
  input  logic [ptr_width(DEPTH)-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  input  logic                          re,
  input  logic [ptr_width(DEPTH)-1:0]   rd_addr,
  output logic [DATA_WIDTH-1:0]         rd_data
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[wr_addr] <= wr_data;
  always_ff @(posedge clk or posedge rst)
    if (rst) rd_data <= '0;
    else rd_data <= re ? mem[rd_addr] : '0;
endmodule

// File: rtl/mean_block_streamer.sv
// mean_block_streamer: buffers a TOTAL_SAMPLES block, pulses start_out, streams the block, then latches the returned mean (ports clk, rst, bus slave; MEAN_STREAMER_TIMEOUT_EN adds a WAIT_MEAN watchdog and sticky timeout_err)
module mean_block_streamer import mean_streamer_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int TOTAL_SAMPLES = DEF_TOTAL_SAMPLES
`ifdef MEAN_STREAMER_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 16
`endif
) (
  input logic clk,
  input logic rst,
  mean_block_streamer_if.slave bus
);
  localparam int PW = ptr_width(TOTAL_SAMPLES);
  state_t state;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic we, re, last_wr, mean_hit, wait_done;
  assign bus.in_ready = state == FILL;
  assign bus.busy = state != FILL;
  assign we = bus.in_valid && bus.in_ready;
  assign last_wr = we && &wr_ptr;
  assign re = state == START || (state == STREAM && rd_ptr != '0);
  assign mean_hit = state == WAIT_MEAN && bus.mean_ready_in;
`ifdef MEAN_STREAMER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;
  logic tmo_fire;
  assign tmo_fire = state == WAIT_MEAN && !bus.mean_ready_in && tmo_cnt == TW'(TIMEOUT_CYCLES - 1);
  assign wait_done = mean_hit || tmo_fire;
`else
  assign wait_done = mean_hit;
`endif
  sample_block_buffer #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(TOTAL_SAMPLES)) u_buf (
    .clk(clk),
    .rst(rst),
    .we(we),
    .wr_addr(wr_ptr),
    .wr_data(bus.in_data),
    .re(re),
    .rd_addr(rd_ptr),
    .rd_data(bus.data_out)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= FILL;
      wr_ptr <= '0;
      rd_ptr <= '0;
      bus.start_out <= 1'b0;
      bus.mean_out <= '0;
      bus.block_done <= 1'b0;
`ifdef MEAN_STREAMER_TIMEOUT_EN
      tmo_cnt <= '0;
      bus.timeout_err <= 1'b0;
`endif
    end else begin
      bus.start_out <= last_wr;
      bus.block_done <= mean_hit;
      if (we) wr_ptr <= wr_ptr + 1'b1;
      if (re) rd_ptr <= rd_ptr + 1'b1;
      if (mean_hit) bus.mean_out <= bus.mean_in;
`ifdef MEAN_STREAMER_TIMEOUT_EN
      tmo_cnt <= state == WAIT_MEAN ? tmo_cnt + 1'b1 : '0;
      if (tmo_fire) bus.timeout_err <= 1'b1;
`endif
      state <= state == FILL   ? (last_wr ? START : FILL) :
               state == START  ? STREAM :
               state == STREAM ? (rd_ptr == '0 ? WAIT_MEAN : STREAM) :
                                 (wait_done ? FILL : WAIT_MEAN);
    end
endmodule

// File: tb/tb_mean_block_streamer.sv
// tb_mean_block_streamer: directed bench with a golden mean unit for mean_block_streamer
module tb_mean_block_streamer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int compares = 0;
  int fails = 0;
  mean_block_streamer_if #(.DATA_WIDTH(8)) bus ();
  mean_block_streamer dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  logic model_en = 1'b1;
  logic model_ready, active, pend;
  logic [15:0] model_mean, sum;
  int cnt;
  logic frc_ready = 1'b0;
  logic [15:0] frc_mean = 16'h0;
  assign bus.mean_ready_in = model_ready | frc_ready;
  assign bus.mean_in = frc_ready ? frc_mean : model_mean;
  always @(posedge clk or posedge rst)
    if (rst) begin
      model_ready <= 1'b0;
      active <= 1'b0;
      pend <= 1'b0;
      model_mean <= 16'h0;
      sum <= 16'h0;
      cnt <= 0;
    end else begin
      model_ready <= 1'b0;
      if (pend) begin
        model_ready <= model_en;
        pend <= 1'b0;
      end
      if (bus.start_out) begin
        active <= 1'b1;
        cnt <= 0;
        sum <= 16'h0;
      end else if (active) begin
        sum <= sum + 16'(bus.data_out);
        cnt <= cnt + 1;
        if (cnt == 63) begin
          active <= 1'b0;
          pend <= 1'b1;
          model_mean <= (sum + 16'(bus.data_out)) / 16'd64;
        end
      end
    end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  task automatic drive_block(input logic [7:0] base, input logic [7:0] step, input bit toggle);
    int i = 0;
    int n = 0;
    while (i < 64 && n < 1000) begin
      bus.in_valid = !toggle || !n[0];
      bus.in_data = base + 8'(i) * step;
      if (bus.in_valid && bus.in_ready) i++;
      n++;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    compares++;
    if (i != 64) begin
      fails++;
      $display("FAIL fill_accepts: accepted %0d, want 64", i);
    end
  endtask
  task automatic test_reset;
    @(negedge clk);
    @(negedge clk);
    compares++;
    if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.data_out !== 8'h0 || bus.start_out !== 1'b0) begin
      fails++;
      $display("FAIL reset_ctrl: in_ready=%b busy=%b data_out=%0h start_out=%b, want 1 0 0 0", bus.in_ready, bus.busy, bus.data_out, bus.start_out);
    end
    compares++;
    if (bus.mean_out !== 16'h0 || bus.block_done !== 1'b0) begin
      fails++;
      $display("FAIL reset_mean: mean_out=%0h block_done=%b, want 0 0", bus.mean_out, bus.block_done);
    end
`ifdef MEAN_STREAMER_TIMEOUT_EN
    compares++;
    if (bus.timeout_err !== 1'b0) begin
      fails++;
      $display("FAIL reset_timeout_err: got %b want 0", bus.timeout_err);
    end
`endif
    rst = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_ramp(input bit toggle);
    drive_block(8'd0, 8'd1, toggle);
    compares++;
    if (bus.start_out !== 1'b1 || bus.busy !== 1'b1 || bus.in_ready !== 1'b0 || bus.data_out !== 8'h0) begin
      fails++;
      $display("FAIL ramp_start(t=%0d): start_out=%b busy=%b in_ready=%b data_out=%0h, want 1 1 0 0", toggle, bus.start_out, bus.busy, bus.in_ready, bus.data_out);
    end
    bus.in_valid = toggle;
    bus.in_data = 8'hEE;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      compares++;
      if (bus.data_out !== 8'(k) || bus.start_out !== 1'b0 || bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin
        fails++;
        $display("FAIL ramp_stream[%0d](t=%0d): data_out=%0d start_out=%b in_ready=%b busy=%b, want %0d 0 0 1", k, toggle, bus.data_out, bus.start_out, bus.in_ready, bus.busy, k);
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    compares++;
    if (bus.data_out !== 8'h0 || bus.busy !== 1'b1 || bus.in_ready !== 1'b0 || bus.block_done !== 1'b0) begin
      fails++;
      $display("FAIL ramp_wait1: data_out=%0h busy=%b in_ready=%b block_done=%b, want 0 1 0 0", bus.data_out, bus.busy, bus.in_ready, bus.block_done);
    end
    @(negedge clk);
    compares++;
    if (bus.block_done !== 1'b0 || bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
      fails++;
      $display("FAIL ramp_wait2: block_done=%b busy=%b in_ready=%b, want 0 1 0", bus.block_done, bus.busy, bus.in_ready);
    end
    @(negedge clk);
    compares++;
    if (bus.block_done !== 1'b1 || bus.mean_out !== 16'd31 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL ramp_done: block_done=%b mean_out=%0d in_ready=%b busy=%b, want 1 31 1 0", bus.block_done, bus.mean_out, bus.in_ready, bus.busy);
    end
    @(negedge clk);
    compares++;
    if (bus.block_done !== 1'b0 || bus.mean_out !== 16'd31) begin
      fails++;
      $display("FAIL ramp_after: block_done=%b mean_out=%0d, want 0 31", bus.block_done, bus.mean_out);
    end
  endtask
  task automatic test_back_to_back;
    drive_block(8'hFF, 8'd0, 1'b0);
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      compares++;
      if (bus.data_out !== 8'hFF) begin
        fails++;
        $display("FAIL b2b_a_stream[%0d]: data_out=%0h want ff", k, bus.data_out);
      end
    end
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    compares++;
    if (bus.block_done !== 1'b1 || bus.in_ready !== 1'b1 || bus.mean_out !== 16'd255) begin
      fails++;
      $display("FAIL b2b_a_done: block_done=%b in_ready=%b mean_out=%0d, want 1 1 255", bus.block_done, bus.in_ready, bus.mean_out);
    end
    drive_block(8'h00, 8'd0, 1'b0);
    compares++;
    if (bus.start_out !== 1'b1) begin
      fails++;
      $display("FAIL b2b_b_start: start_out=%b want 1", bus.start_out);
    end
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      compares++;
      if (bus.data_out !== 8'h00) begin
        fails++;
        $display("FAIL b2b_b_stream[%0d]: data_out=%0h want 0", k, bus.data_out);
      end
    end
    @(negedge clk);
    @(negedge clk);
    compares++;
    if (bus.block_done !== 1'b0 || bus.mean_out !== 16'd255) begin
      fails++;
      $display("FAIL b2b_b_wait: block_done=%b mean_out=%0d, want 0 255", bus.block_done, bus.mean_out);
    end
    @(negedge clk);
    compares++;
    if (bus.block_done !== 1'b1 || bus.mean_out !== 16'd0) begin
      fails++;
      $display("FAIL b2b_b_done: block_done=%b mean_out=%0d, want 1 0", bus.block_done, bus.mean_out);
    end
    @(negedge clk);
  endtask
  task automatic test_ignored_ready;
    frc_mean = 16'hABCD;
    frc_ready = 1'b1;
    @(negedge clk);
    frc_ready = 1'b0;
    compares++;
    if (bus.block_done !== 1'b0 || bus.mean_out !== 16'd0) begin
      fails++;
      $display("FAIL ign_fill: block_done=%b mean_out=%0h, want 0 0", bus.block_done, bus.mean_out);
    end
    drive_block(8'd100, 8'd0, 1'b0);
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      frc_ready = k == 5;
      if (k == 6) begin
        compares++;
        if (bus.block_done !== 1'b0 || bus.mean_out !== 16'd0 || bus.busy !== 1'b1) begin
          fails++;
          $display("FAIL ign_stream: block_done=%b mean_out=%0h busy=%b, want 0 0 1", bus.block_done, bus.mean_out, bus.busy);
        end
      end
    end
    frc_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    compares++;
    if (bus.block_done !== 1'b1 || bus.mean_out !== 16'd100) begin
      fails++;
      $display("FAIL ign_done: block_done=%b mean_out=%0d, want 1 100", bus.block_done, bus.mean_out);
    end
    @(negedge clk);
  endtask
  task automatic test_reset_mid;
    drive_block(8'd0, 8'd1, 1'b0);
    for (int k = 0; k <= 10; k++) @(negedge clk);
    compares++;
    if (bus.data_out !== 8'd10) begin
      fails++;
      $display("FAIL rstmid_pre: data_out=%0d want 10", bus.data_out);
    end
    #2 rst = 1'b1;
    #1;
    compares++;
    if (bus.data_out !== 8'h0 || bus.start_out !== 1'b0 || bus.mean_out !== 16'h0) begin
      fails++;
      $display("FAIL rstmid_async: data_out=%0h start_out=%b mean_out=%0h, want 0 0 0", bus.data_out, bus.start_out, bus.mean_out);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    compares++;
    if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.block_done !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_release: in_ready=%b busy=%b block_done=%b, want 1 0 0", bus.in_ready, bus.busy, bus.block_done);
    end
    test_ramp(1'b0);
  endtask
`ifdef MEAN_STREAMER_TIMEOUT_EN
  task automatic test_timeout;
    model_en = 1'b0;
    drive_block(8'd0, 8'd1, 1'b0);
    for (int k = 0; k < 64; k++) @(negedge clk);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      compares++;
      if (bus.timeout_err !== 1'b0 || bus.in_ready !== 1'b0) begin
        fails++;
        $display("FAIL tmo_wait[%0d]: timeout_err=%b in_ready=%b, want 0 0", k, bus.timeout_err, bus.in_ready);
      end
    end
    @(negedge clk);
    compares++;
    if (bus.timeout_err !== 1'b1 || bus.in_ready !== 1'b1 || bus.block_done !== 1'b0 || bus.mean_out !== 16'd31) begin
      fails++;
      $display("FAIL tmo_fire: timeout_err=%b in_ready=%b block_done=%b mean_out=%0d, want 1 1 0 31", bus.timeout_err, bus.in_ready, bus.block_done, bus.mean_out);
    end
    @(negedge clk);
    compares++;
    if (bus.timeout_err !== 1'b1) begin
      fails++;
      $display("FAIL tmo_sticky: timeout_err=%b want 1", bus.timeout_err);
    end
    model_en = 1'b1;
  endtask
`endif
  initial begin
    bus.in_valid = 1'b0;
    bus.in_data = 8'h0;
    test_reset;
    test_ramp(1'b0);
    test_ramp(1'b1);
    test_back_to_back;
    test_ignored_ready;
    test_reset_mid;
`ifdef MEAN_STREAMER_TIMEOUT_EN
    test_timeout;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end
endmodule
